reproductor_melodia: RTL and testbench

- Sequencer and tone generator that reads the 25-entry melody note ROM.
- Drives direccion_nota[4:0] to the ROM and consumes the returned 16-bit frecuencia_de_nota, a half-period in clk cycles at 48 MHz.
- Produces a square-wave buzzer output, one note per slot, with a silent gap between notes.
- Sits between the top-level start/stop controls and the board buzzer pin.

---
 rtl/reproductor_melodia_pkg.sv | 25 ++
 rtl/reproductor_melodia_divisor_tono.sv | 59 +++++
 rtl/reproductor_melodia.sv | 132 +++++++++++++
 tb/tb_reproductor_melodia.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reproductor_melodia_pkg.sv
// Shared types and constants for the melody player.
// Latency: none (declarations only).
// Backpressure: not applicable.
package melodia_pkg;

    typedef enum logic [1:0] {
        REPOSO,
        CARGA,
        TONO,
        SILENCIO
    } estado_t;

    localparam int NUM_NOTAS_DEF      = 25;
    localparam int ANCHO_DIR          = 5;
    localparam int ANCHO_FREC         = 16;
    localparam int FRECUENCIA_CLK_DEF = 48000000;

    // Width of the duration counter shared by the tone and silence phases.
    function automatic int ancho_duracion(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/reproductor_melodia_divisor_tono.sv
// Half-period divider: latches a note's half-period and toggles a square wave.
// Latency: onda changes one edge after the counter hits periodo-1.
// Backpressure: none; driven purely by the cargar/habilitar strobes.
module divisor_tono
    import melodia_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  habilitar,
    input  logic                  cargar,
    input  logic [ANCHO_FREC-1:0] periodo,
    output logic                  onda
);

    logic [ANCHO_FREC-1:0] periodo_q, periodo_d;
    logic [ANCHO_FREC-1:0] cnt_q, cnt_d;
    logic                  onda_q, onda_d;

    // Next-state: load on cargar, count/toggle while enabled, otherwise park low.
    always_comb begin
        periodo_d = periodo_q;
        cnt_d     = cnt_q;
        onda_d    = onda_q;
        if (cargar) begin
            periodo_d = periodo;
            cnt_d     = '0;
            onda_d    = 1'b0;
        end else if (habilitar) begin
            // A zero half-period is a rest: counter and output stay frozen.
            if (periodo_q != '0) begin
                if (cnt_q == periodo_q - ANCHO_FREC'(1)) begin
                    cnt_d  = '0;
                    onda_d = ~onda_q;
                end else begin
                    cnt_d = cnt_q + ANCHO_FREC'(1);
                end
            end
        end else begin
            cnt_d  = '0;
            onda_d = 1'b0;
        end
    end

    // Register divider state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            periodo_q <= '0;
            cnt_q     <= '0;
            onda_q    <= 1'b0;
        end else begin
            periodo_q <= periodo_d;
            cnt_q     <= cnt_d;
            onda_q    <= onda_d;
        end
    end

    assign onda = onda_q;

endmodule

// File: rtl/reproductor_melodia.sv
// Melody sequencer: walks the note ROM, sounds each note then a silent gap.
// Latency: 2 edges from iniciar to tone; 1+CICLOS_NOTA+CICLOS_SILENCIO per note.
// Backpressure: none; detener aborts at the next edge. REPRODUCTOR_REPETIR_EN loops playback.
module reproductor_melodia
    import melodia_pkg::*;
#(
    parameter int NUM_NOTAS       = NUM_NOTAS_DEF,
    parameter int CICLOS_NOTA     = 12000000,
    parameter int CICLOS_SILENCIO = 2400000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iniciar,
    input  logic                  detener,
    input  logic [ANCHO_FREC-1:0] frecuencia_de_nota,
    output logic [ANCHO_DIR-1:0]  direccion_nota,
    output logic                  buzzer,
    output logic                  reproduciendo,
    output logic                  fin
);

    localparam int ANCHO_DUR = ancho_duracion(CICLOS_NOTA, CICLOS_SILENCIO);
    localparam logic [ANCHO_DUR-1:0] FIN_TONO     = ANCHO_DUR'(CICLOS_NOTA - 1);
    localparam logic [ANCHO_DUR-1:0] FIN_SILENCIO = ANCHO_DUR'(CICLOS_SILENCIO - 1);
    localparam logic [ANCHO_DIR-1:0] ULTIMA_NOTA  = ANCHO_DIR'(NUM_NOTAS - 1);

    estado_t              estado_q, estado_d;
    logic [ANCHO_DIR-1:0] dir_q, dir_d;
    logic [ANCHO_DUR-1:0] dur_q, dur_d;
    logic                 rep_q, rep_d;
    logic                 fin_q, fin_d;
    logic                 cargar, habilitar;

    // Sequencing decisions; habilitar drops on the last tone cycle so the
    // divider forces the buzzer low on the edge into SILENCIO.
    always_comb begin
        estado_d  = estado_q;
        dir_d     = dir_q;
        dur_d     = dur_q;
        fin_d     = 1'b0;
        cargar    = 1'b0;
        habilitar = 1'b0;
        case (estado_q)
            REPOSO: begin
                dir_d = '0;
                dur_d = '0;
                if (iniciar && !detener) begin
                    estado_d = CARGA;
                end
            end
            CARGA: begin
                cargar   = 1'b1;
                dur_d    = '0;
                estado_d = TONO;
            end
            TONO: begin
                if (dur_q == FIN_TONO) begin
                    dur_d    = '0;
                    estado_d = SILENCIO;
                end else begin
                    dur_d     = dur_q + ANCHO_DUR'(1);
                    habilitar = 1'b1;
                end
            end
            SILENCIO: begin
                if (dur_q == FIN_SILENCIO) begin
                    dur_d = '0;
                    if (dir_q == ULTIMA_NOTA) begin
                        fin_d = 1'b1;
                        dir_d = '0;
`ifdef REPRODUCTOR_REPETIR_EN
                        estado_d = CARGA;
`else
                        estado_d = REPOSO;
`endif
                    end else begin
                        dir_d    = dir_q + ANCHO_DIR'(1);
                        estado_d = CARGA;
                    end
                end else begin
                    dur_d = dur_q + ANCHO_DUR'(1);
                end
            end
            default: begin
                estado_d = REPOSO;
                dir_d    = '0;
                dur_d    = '0;
            end
        endcase
        // Stop has priority over everything, including the final fin pulse.
        if (detener && (estado_q != REPOSO)) begin
            estado_d  = REPOSO;
            dir_d     = '0;
            dur_d     = '0;
            fin_d     = 1'b0;
            cargar    = 1'b0;
            habilitar = 1'b0;
        end
        rep_d = (estado_d != REPOSO);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= REPOSO;
            dir_q    <= '0;
            dur_q    <= '0;
            rep_q    <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            dir_q    <= dir_d;
            dur_q    <= dur_d;
            rep_q    <= rep_d;
            fin_q    <= fin_d;
        end
    end

    divisor_tono u_divisor (
        .clk       (clk),
        .rst       (rst),
        .habilitar (habilitar),
        .cargar    (cargar),
        .periodo   (frecuencia_de_nota),
        .onda      (buzzer)
    );

    assign direccion_nota = dir_q;
    assign reproduciendo  = rep_q;
    assign fin            = fin_q;

endmodule

// File: tb/tb_reproductor_melodia.sv
// Bench for reproductor_melodia with a small ROM stub and a timeline reference model.
// Latency: expectations are checked one edge after the inputs that cause them.
// Backpressure: not applicable.
module tb_reproductor_melodia;

    localparam int T_NOTA   = 20;
    localparam int T_SIL    = 4;
    localparam int N_NOTAS  = 3;
    localparam int POR_NOTA = 1 + T_NOTA + T_SIL;
    localparam int PASADA   = N_NOTAS * POR_NOTA;

    typedef struct {
        bit       rep;
        bit       buz;
        bit [4:0] dir;
        bit       fin;
    } esperado_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iniciar;
    logic        detener;
    logic [15:0] frecuencia_de_nota;
    logic [4:0]  direccion_nota;
    logic        buzzer;
    logic        reproduciendo;
    logic        fin;

    logic [15:0] rom [32];
    esperado_t   cola [$];
    int          vectores = 0;
    int          fallos   = 0;

    // Reference model state: whether a pass is active and the cycle index within it.
    bit          tocando = 1'b0;
    int          pos     = 0;
    bit          fin_m   = 1'b0;

    always #5 clk = ~clk;

    assign frecuencia_de_nota = rom[direccion_nota];

    reproductor_melodia #(
        .NUM_NOTAS       (N_NOTAS),
        .CICLOS_NOTA     (T_NOTA),
        .CICLOS_SILENCIO (T_SIL)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .iniciar            (iniciar),
        .detener            (detener),
        .frecuencia_de_nota (frecuencia_de_nota),
        .direccion_nota     (direccion_nota),
        .buzzer             (buzzer),
        .reproduciendo      (reproduciendo),
        .fin                (fin)
    );

    // Buzzer level at cycle p of a pass: tone k cycles into a note is high
    // during odd half-periods; CARGA and silence cycles are low.
    function automatic bit tono(input int p);
        int off, k, per;
        off = p % POR_NOTA;
        if (off < 1 || off > T_NOTA) return 1'b0;
        k   = off - 1;
        per = int'(rom[p / POR_NOTA]);
        if (per == 0) return 1'b0;
        return ((k / per) % 2) == 1;
    endfunction

    // Advance the model by one edge and queue what the DUT should show after it.
    task automatic modelo(input bit ini, input bit det, input bit r);
        esperado_t e;
        if (r) begin
            tocando = 1'b0;
            fin_m   = 1'b0;
        end else if (!tocando) begin
            fin_m = 1'b0;
            if (ini && !det) begin
                tocando = 1'b1;
                pos     = 0;
            end
        end else if (det) begin
            tocando = 1'b0;
            fin_m   = 1'b0;
        end else begin
            pos   = pos + 1;
            fin_m = 1'b0;
            if (pos == PASADA) begin
                fin_m = 1'b1;
                pos   = 0;
`ifndef REPRODUCTOR_REPETIR_EN
                tocando = 1'b0;
`endif
            end
        end
        e.rep = tocando;
        e.dir = tocando ? 5'(pos / POR_NOTA) : 5'd0;
        e.buz = tocando ? tono(pos) : 1'b0;
        e.fin = fin_m;
        cola.push_back(e);
    endtask

    task automatic comparar(input string nombre, input esperado_t e);
        vectores++;
        if (reproduciendo !== e.rep || buzzer !== e.buz ||
            direccion_nota !== e.dir || fin !== e.fin) begin
            fallos++;
            $display("FAIL %s t=%0t: got rep=%0b buz=%0b dir=%0d fin=%0b, expected rep=%0b buz=%0b dir=%0d fin=%0b",
                     nombre, $time, reproduciendo, buzzer, direccion_nota, fin,
                     e.rep, e.buz, e.dir, e.fin);
        end
    endtask

    // Monitor: one expectation per edge, compared just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cola.size() > 0) comparar("salidas", cola.pop_front());
        end
    end

    task automatic ciclo(input bit ini, input bit det);
        iniciar = ini;
        detener = det;
        modelo(ini, det, 1'b0);
        @(posedge clk);
        #2;
    endtask

    task automatic esperar(input int n);
        repeat (n) ciclo(1'b0, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge.
    task automatic reset_async();
        esperado_t cero;
        cero = '{rep: 1'b0, buz: 1'b0, dir: 5'd0, fin: 1'b0};
        iniciar = 1'b0;
        detener = 1'b0;
        rst     = 1'b1;
        #1;
        comparar("reset_asincrono", cero);
        modelo(1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        esperado_t cero;
        cero = '{rep: 1'b0, buz: 1'b0, dir: 5'd0, fin: 1'b0};
        rst     = 1'b0;
        iniciar = 1'b0;
        detener = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 16'd0;
        rom[0] = 16'd3;
        rom[1] = 16'd5;
        rom[2] = 16'd0;

        #1 rst = 1'b1;
        #2 comparar("reset_inicial", cero);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Full pass with the fixed ROM.
        esperar(3);
        ciclo(1'b1, 1'b0);
        esperar(80);

        // iniciar held during play must not restart the pass.
        ciclo(1'b1, 1'b0);
        repeat (40) ciclo(1'b1, 1'b0);
        esperar(40);

        // detener during note 1 tone, then iniciar and detener together.
        ciclo(1'b1, 1'b0);
        esperar(30);
        ciclo(1'b0, 1'b1);
        esperar(5);
        ciclo(1'b1, 1'b1);
        esperar(5);

        // detener on the final silence cycle suppresses fin.
        ciclo(1'b1, 1'b0);
        esperar(PASADA - 1);
        ciclo(1'b0, 1'b1);
        esperar(5);

        // Asynchronous reset mid-tone.
        ciclo(1'b1, 1'b0);
        esperar(10);
        reset_async();
        esperar(5);

        // Random ROM contents and random start/stop requests.
        for (int b = 0; b < 15; b++) begin
            ciclo(1'b0, 1'b1);
            for (int i = 0; i < N_NOTAS; i++) rom[i] = 16'($urandom_range(0, 9));
            for (int c = 0; c < 120; c++) begin
                ciclo($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
            end
        end

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
        $finish;
    end

endmodule
